// File: rtl/proc_program_feeder.sv
// Program feeder: fetches 9-bit words from a synchronous program ROM and issues them to proc
// over DIN/Run, pacing on Done, with mvi immediates, HALT/end-of-program and a Done watchdog.
module proc_program_feeder #(
   parameter int AW       = 5,
   parameter int PROG_LEN = 32,
   parameter int TIMEOUT  = 15,
   parameter int CW       = 16
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Abort,
   input  logic          Done,
   input  logic [8:0]    MemData,
   output logic [AW-1:0] MemAddr,
   output logic [8:0]    DIN,
   output logic          Run,
   output logic          Busy,
   output logic          Halted,
   output logic          Error,
   output logic [CW-1:0] InstrCount
);

   localparam int              WW       = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]     LAST_PC  = (AW+1)'(PROG_LEN - 1);
   localparam logic [AW:0]     END_PC   = (AW+1)'(PROG_LEN);
   localparam logic [AW:0]     PC_ONE   = (AW+1)'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [WW-1:0]   WD_ONE   = WW'(1);
   localparam logic [WW-1:0]   WD_LIMIT = WW'(TIMEOUT);
   localparam logic [2:0]      OP_MVI   = 3'b001;
   localparam logic [2:0]      OP_HALT  = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_HALTED    = 4'd1,
      S_ERROR     = 4'd2,
      S_FETCH     = 4'd3,
      S_LATCH     = 4'd4,
      S_FETCH_IMM = 4'd5,
      S_LATCH_IMM = 4'd6,
      S_ISSUE     = 4'd7,
      S_WAIT_DONE = 4'd8
   } state_t;

   state_t        state_r, state_s;
   logic [AW:0]   pc_r, pc_s;
   logic [8:0]    instr_r, instr_s;
   logic [8:0]    imm_r, imm_s;
   logic [WW-1:0] wd_r, wd_s;
   logic [CW-1:0] count_s;
   logic          abort_r, abort_s;
   logic [8:0]    din_s;
   logic          run_s, busy_s, halted_s, error_s;

   // Next-state, program counter, instruction/immediate capture, watchdog and abort bookkeeping
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      imm_s   = imm_r;
      wd_s    = wd_r;
      count_s = InstrCount;
      abort_s = abort_r | Abort;
      case (state_r)
         S_IDLE, S_HALTED, S_ERROR: begin
            if (Start) begin
               state_s = S_FETCH;
               pc_s    = '0;
               count_s = '0;
               abort_s = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         S_FETCH: state_s = S_LATCH;
         S_LATCH: begin
            if (abort_s) begin
               state_s = S_IDLE;
               abort_s = 1'b0;
            end else if (MemData[8:6] == OP_HALT) begin
               state_s = S_HALTED;
            end else begin
               instr_s = MemData;
               pc_s    = pc_r + PC_ONE;
               if (MemData[8:6] == OP_MVI) begin
                  // an mvi in the last slot has no immediate word to read
                  if (pc_r == LAST_PC) begin
                     state_s = S_ERROR;
                  end else begin
                     state_s = S_FETCH_IMM;
                  end
               end else begin
                  state_s = S_ISSUE;
               end
            end
         end
         S_FETCH_IMM: state_s = S_LATCH_IMM;
         S_LATCH_IMM: begin
            imm_s   = MemData;
            pc_s    = pc_r + PC_ONE;
            state_s = S_ISSUE;
         end
         S_ISSUE: begin
            wd_s    = '0;
            state_s = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (Done) begin
               count_s = InstrCount + CNT_ONE;
               if (abort_s) begin
                  state_s = S_IDLE;
                  abort_s = 1'b0;
               end else if (pc_r == END_PC) begin
                  state_s = S_HALTED;
               end else begin
                  state_s = S_FETCH;
               end
            end else if (wd_r == WD_LIMIT) begin
               state_s = S_ERROR;
            end else begin
               wd_s = wd_r + WD_ONE;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output leaves a flop
   always_comb begin
      run_s    = (state_s == S_ISSUE);
      busy_s   = !(state_s inside {S_IDLE, S_HALTED, S_ERROR});
      halted_s = (state_s == S_HALTED);
      error_s  = (state_s == S_ERROR);
      case (state_s)
         S_ISSUE: din_s = instr_s;
         S_WAIT_DONE: begin
            if (instr_s[8:6] == OP_MVI) begin
               din_s = imm_s;
            end else begin
               din_s = 9'd0;
            end
         end
         default: din_s = 9'd0;
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r    <= S_IDLE;
         pc_r       <= '0;
         instr_r    <= 9'd0;
         imm_r      <= 9'd0;
         wd_r       <= '0;
         abort_r    <= 1'b0;
         InstrCount <= '0;
         MemAddr    <= '0;
         DIN        <= 9'd0;
         Run        <= 1'b0;
         Busy       <= 1'b0;
         Halted     <= 1'b0;
         Error      <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         instr_r    <= instr_s;
         imm_r      <= imm_s;
         wd_r       <= wd_s;
         abort_r    <= abort_s;
         InstrCount <= count_s;
         MemAddr    <= pc_s[AW-1:0];
         DIN        <= din_s;
         Run        <= run_s;
         Busy       <= busy_s;
         Halted     <= halted_s;
         Error      <= error_s;
      end
   end

endmodule

// File: tb/tb_proc_program_feeder.sv
// Bench for proc_program_feeder: synchronous ROM model, Done responder, table-driven
// single-program vectors plus hand-written timeout, mvi-at-end, abort and reset sequences.
module tb_proc_program_feeder;

   localparam int         AW       = 3;
   localparam int         PROG_LEN = 8;
   localparam int         TIMEOUT  = 15;
   localparam int         CW       = 16;
   localparam logic [8:0] HALT_W   = 9'h1C0;

   logic          Clock, Reset, Start, Abort, Done;
   logic [8:0]    MemData;
   logic [AW-1:0] MemAddr;
   logic [8:0]    DIN;
   logic          Run, Busy, Halted, Error;
   logic [CW-1:0] InstrCount;

   logic [8:0] rom [0:PROG_LEN-1];
   int         tests = 0;
   int         fails = 0;
   logic       done_en;
   int         done_dly;

   typedef struct {
      logic [8:0] w0;
      logic [8:0] w1;
      int         runs;
      logic [8:0] din0;
      logic [8:0] wait0;
      int         max_addr;
   } vec_t;

   proc_program_feeder #(.AW(AW), .PROG_LEN(PROG_LEN), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Done(Done),
      .MemData(MemData), .MemAddr(MemAddr), .DIN(DIN), .Run(Run), .Busy(Busy),
      .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always @(posedge Clock) MemData <= rom[MemAddr];

   // proc stand-in: raise Done for one cycle done_dly cycles after each Run
   initial begin
      Done = 1'b0;
      forever begin
         @(negedge Clock);
         if (Run && done_en) begin
            repeat (done_dly) @(negedge Clock);
            Done = 1'b1;
            @(negedge Clock);
            Done = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fill_rom(input logic [8:0] w);
      for (int a = 0; a < PROG_LEN; a++) rom[a] = w;
   endtask

   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   task automatic wait_run(input string name);
      int n = 0;
      while (!Run && n < 100) begin
         @(negedge Clock);
         n++;
      end
      check(name, int'(Run), 1);
   endtask

   task automatic wait_idle(input string name, output int runs);
      int n = 0;
      runs = 0;
      while (Busy && n < 300) begin
         @(negedge Clock);
         n++;
         if (Run) runs++;
      end
      check(name, int'(Busy), 0);
   endtask

   task automatic run_prog(input string name, output int runs, output logic [8:0] din0,
                           output logic [8:0] wait0, output int halt_runs,
                           output int dbl_runs, output int max_addr);
      int   n        = 0;
      logic prev_run = 1'b0;
      runs      = 0;
      din0      = 9'd0;
      wait0     = 9'd0;
      halt_runs = 0;
      dbl_runs  = 0;
      max_addr  = 0;
      pulse_start();
      while (Busy && n < 300) begin
         @(negedge Clock);
         n++;
         if (prev_run && runs == 1) wait0 = DIN;
         if (Run) begin
            runs++;
            if (runs == 1) din0 = DIN;
            if (DIN == HALT_W) halt_runs++;
            if (prev_run) dbl_runs++;
         end
         prev_run = Run;
         if (int'(MemAddr) > max_addr) max_addr = int'(MemAddr);
      end
      check({name, " finished"}, int'(Busy), 0);
   endtask

   initial begin
      vec_t       vecs [6];
      int         runs, halt_runs, dbl_runs, max_addr, cyc;
      logic [8:0] din0, wait0;

      // {word0, word1, runs, DIN at first Run, DIN while waiting, max MemAddr}; rest HALT
      vecs[0] = '{9'h040, 9'h005, 1, 9'h040, 9'h005, 2};
      vecs[1] = '{9'h080, 9'h0C0, 2, 9'h080, 9'h000, 2};
      vecs[2] = '{9'h001, HALT_W, 1, 9'h001, 9'h000, 1};
      vecs[3] = '{HALT_W, 9'h080, 0, 9'h000, 9'h000, 0};
      vecs[4] = '{9'h13F, 9'h1BF, 2, 9'h13F, 9'h000, 2};
      vecs[5] = '{9'h040, 9'h1FF, 1, 9'h040, 9'h1FF, 2};

      Reset    = 1'b1;
      Start    = 1'b0;
      Abort    = 1'b0;
      done_en  = 1'b1;
      done_dly = 2;
      fill_rom(HALT_W);

      repeat (2) @(negedge Clock);
      check("rst MemAddr", int'(MemAddr), 0);
      check("rst DIN", int'(DIN), 0);
      check("rst Run", int'(Run), 0);
      check("rst Busy", int'(Busy), 0);
      check("rst Halted", int'(Halted), 0);
      check("rst Error", int'(Error), 0);
      check("rst InstrCount", int'(InstrCount), 0);
      Reset = 1'b0;
      @(negedge Clock);

      for (int i = 0; i < 6; i++) begin
         fill_rom(HALT_W);
         rom[0] = vecs[i].w0;
         rom[1] = vecs[i].w1;
         run_prog($sformatf("v%0d", i), runs, din0, wait0, halt_runs, dbl_runs, max_addr);
         check($sformatf("v%0d runs", i), runs, vecs[i].runs);
         check($sformatf("v%0d count", i), int'(InstrCount), vecs[i].runs);
         check($sformatf("v%0d halted", i), int'(Halted), 1);
         check($sformatf("v%0d error", i), int'(Error), 0);
         check($sformatf("v%0d halt issued", i), halt_runs, 0);
         check($sformatf("v%0d max addr", i), max_addr, vecs[i].max_addr);
         if (vecs[i].runs > 0) begin
            check($sformatf("v%0d din issue", i), int'(din0), int'(vecs[i].din0));
            check($sformatf("v%0d din wait", i), int'(wait0), int'(vecs[i].wait0));
         end
      end

      // full program ending at PC == PROG_LEN == 2**AW
      rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h080; rom[3] = 9'h0C0;
      rom[4] = 9'h001; rom[5] = 9'h100; rom[6] = 9'h180; rom[7] = 9'h002;
      run_prog("full", runs, din0, wait0, halt_runs, dbl_runs, max_addr);
      check("full runs", runs, 7);
      check("full count", int'(InstrCount), 7);
      check("full din issue", int'(din0), 9'h040);
      check("full din wait", int'(wait0), 9'h005);
      check("full run width", dbl_runs, 0);
      check("full max addr", max_addr, 7);
      check("full halted", int'(Halted), 1);
      check("full addr wrap", int'(MemAddr), 0);

      // watchdog: Done never comes
      fill_rom(HALT_W);
      rom[0] = 9'h080; rom[1] = 9'h0C0;
      done_en = 1'b0;
      pulse_start();
      wait_run("wd run");
      cyc = 0;
      while (!Error && cyc < 40) begin
         @(negedge Clock);
         cyc++;
      end
      check("wd error latency", cyc, 17);
      check("wd error", int'(Error), 1);
      check("wd busy", int'(Busy), 0);
      check("wd count", int'(InstrCount), 0);
      check("wd run", int'(Run), 0);
      done_en = 1'b1;
      pulse_start();
      check("wd restart addr", int'(MemAddr), 0);
      check("wd restart error", int'(Error), 0);
      check("wd restart busy", int'(Busy), 1);
      wait_idle("wd rerun", runs);
      check("wd rerun runs", runs, 2);
      check("wd rerun halted", int'(Halted), 1);

      // mvi in the last slot
      for (int a = 0; a < PROG_LEN - 1; a++) rom[a] = 9'h080;
      rom[PROG_LEN-1] = 9'h040;
      run_prog("lastmvi", runs, din0, wait0, halt_runs, dbl_runs, max_addr);
      check("lastmvi runs", runs, 7);
      check("lastmvi count", int'(InstrCount), 7);
      check("lastmvi error", int'(Error), 1);
      check("lastmvi halted", int'(Halted), 0);

      // abort during WAIT_DONE, with a Start that must be ignored
      fill_rom(HALT_W);
      rom[0] = 9'h080; rom[1] = 9'h0C0; rom[2] = 9'h100;
      done_dly = 4;
      pulse_start();
      wait_run("abort run");
      @(negedge Clock);
      Abort = 1'b1;
      Start = 1'b1;
      @(negedge Clock);
      Abort = 1'b0;
      Start = 1'b0;
      check("abort start ignored", int'(MemAddr), 1);
      check("abort still busy", int'(Busy), 1);
      wait_idle("abort idle", runs);
      check("abort extra runs", runs, 0);
      check("abort count", int'(InstrCount), 1);
      check("abort halted", int'(Halted), 0);
      check("abort error", int'(Error), 0);
      check("abort pc kept", int'(MemAddr), 1);

      // abort before issue
      pulse_start();
      Abort = 1'b1;
      @(negedge Clock);
      Abort = 1'b0;
      wait_idle("preabort idle", runs);
      check("preabort runs", runs, 0);
      check("preabort count", int'(InstrCount), 0);
      check("preabort addr", int'(MemAddr), 0);

      // reset while waiting on the immediate of an mvi
      fill_rom(HALT_W);
      rom[0] = 9'h080; rom[1] = 9'h040; rom[2] = 9'h0AA;
      done_dly = 3;
      pulse_start();
      wait_run("rstmid run1");
      @(negedge Clock);
      wait_run("rstmid run2");
      @(negedge Clock);
      check("rstmid imm", int'(DIN), 9'h0AA);
      check("rstmid count", int'(InstrCount), 1);
      Reset = 1'b1;
      #1;
      check("rstmid Run", int'(Run), 0);
      check("rstmid Busy", int'(Busy), 0);
      check("rstmid DIN", int'(DIN), 0);
      check("rstmid MemAddr", int'(MemAddr), 0);
      check("rstmid InstrCount", int'(InstrCount), 0);
      check("rstmid Halted", int'(Halted), 0);
      check("rstmid Error", int'(Error), 0);
      @(negedge Clock);
      Reset = 1'b0;
      repeat (4) @(negedge Clock);
      check("rstmid late done count", int'(InstrCount), 0);
      check("rstmid late done busy", int'(Busy), 0);
      check("rstmid late done run", int'(Run), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
